// File: rtl/disp_regctrl.sv
// Display register-bus responder: DISPADDR/DISPCTRL/DISPINT/DISPFIFO and the
// display-side controls derived from them (start address, enable, VBLANK irq).
// Latency: writes take effect at the WREN edge; RDATA is valid one cycle after
// RDEN is first sampled. Backpressure: none; a write or a read every cycle is
// accepted with no wait states.
//
// Ports (all synchronous to ACLK, rising edge):
//   ACLK, ARESET    clock; asynchronous active-high reset
//   WRADDR/BYTEEN/WREN/WDATA   single-cycle write strobe with byte enables
//   RDADDR/RDEN/RDATA          read strobe (held >=2 cycles), registered data
//   VBLANK_PLS, FIFO_OVER_PLS, FIFO_UNDER_PLS   one-cycle event pulses
//   DISP_ADDR, DISP_ON, DSP_IRQ                 outputs to display pipeline/CPU

module disp_regctrl #(
  parameter int C_ADDR_WIDTH = 16,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [C_ADDR_WIDTH-1:0]   WRADDR,
  input  logic [C_DATA_WIDTH/8-1:0] BYTEEN,
  input  logic                      WREN,
  input  logic [C_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_ADDR_WIDTH-1:0]   RDADDR,
  input  logic                      RDEN,
  output logic [C_DATA_WIDTH-1:0]   RDATA,
  input  logic                      VBLANK_PLS,
  input  logic                      FIFO_OVER_PLS,
  input  logic                      FIFO_UNDER_PLS,
  output logic [C_DATA_WIDTH-1:0]   DISP_ADDR,
  output logic                      DISP_ON,
  output logic                      DSP_IRQ
);

  // Register offsets; decode compares every address bit.
  localparam logic [C_ADDR_WIDTH-1:0] ADDR_DISPADDR = C_ADDR_WIDTH'(16'h0000);
  localparam logic [C_ADDR_WIDTH-1:0] ADDR_DISPCTRL = C_ADDR_WIDTH'(16'h0004);
  localparam logic [C_ADDR_WIDTH-1:0] ADDR_DISPINT  = C_ADDR_WIDTH'(16'h0008);
  localparam logic [C_ADDR_WIDTH-1:0] ADDR_DISPFIFO = C_ADDR_WIDTH'(16'h000C);

  // ---------------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------------
  logic [31:3] shadow_addr;   // DISPADDR[31:3]; [2:0] are hardwired to 0
  logic        disp_on;       // DISPCTRL.DISPON
  logic        vblank_flag;   // DISPCTRL.VBLANK (sticky)
  logic        int_enbl;      // DISPINT.INTENBL
  logic        int_flag;      // DISPINT.INTFLAG (sticky)
  logic        fifo_under;    // DISPFIFO.UNDER (sticky)
  logic        fifo_over;     // DISPFIFO.OVER (sticky)

  logic [31:0] disp_addr;
  logic        dsp_irq;
  logic [31:0] rdata;

  // ---------------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------------
  logic wr_addr_sel;
  logic wr_ctrl_sel;
  logic wr_int_sel;
  logic wr_fifo_sel;

  assign wr_addr_sel = WREN && (WRADDR == ADDR_DISPADDR);
  assign wr_ctrl_sel = WREN && (WRADDR == ADDR_DISPCTRL);
  assign wr_int_sel  = WREN && (WRADDR == ADDR_DISPINT);
  assign wr_fifo_sel = WREN && (WRADDR == ADDR_DISPFIFO);

  // All control/status fields live in byte 0, so byte 0 gates both the RW
  // fields and the write-1-to-clear actions of those three registers.
  logic wr_ctrl_b0;
  logic wr_int_b0;
  logic wr_fifo_b0;

  assign wr_ctrl_b0 = wr_ctrl_sel && BYTEEN[0];
  assign wr_int_b0  = wr_int_sel  && BYTEEN[0];
  assign wr_fifo_b0 = wr_fifo_sel && BYTEEN[0];

  // Write-1-to-clear requests.
  logic clr_vblank;
  logic clr_int;
  logic clr_under;
  logic clr_over;

  assign clr_vblank = wr_ctrl_b0 && WDATA[1];
  assign clr_int    = wr_int_b0  && WDATA[1];
  assign clr_under  = wr_fifo_b0 && WDATA[0];
  assign clr_over   = wr_fifo_b0 && WDATA[1];

  // WDATA[2] only ever targets DISPADDR[2] (forced 0) or the read-only INTFLAG.
  logic unused_wdata_bit2;
  assign unused_wdata_bit2 = WDATA[2];

  // ---------------------------------------------------------------------------
  // DISPADDR shadow: byte-granular, low three bits never stored.
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      shadow_addr <= '0;
    end else if (wr_addr_sel) begin
      if (BYTEEN[0]) shadow_addr[7:3]   <= WDATA[7:3];
      if (BYTEEN[1]) shadow_addr[15:8]  <= WDATA[15:8];
      if (BYTEEN[2]) shadow_addr[23:16] <= WDATA[23:16];
      if (BYTEEN[3]) shadow_addr[31:24] <= WDATA[31:24];
    end
  end

  logic [31:0] shadow_full;
  assign shadow_full = {shadow_addr, 3'b000};

  // ---------------------------------------------------------------------------
  // Control bits and sticky status flags.
  // Sticky update is set | (hold & ~clear): a hardware pulse in the same cycle
  // as a W1C write leaves the bit set.
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      disp_on     <= 1'b0;
      vblank_flag <= 1'b0;
      int_enbl    <= 1'b0;
      int_flag    <= 1'b0;
      fifo_under  <= 1'b0;
      fifo_over   <= 1'b0;
    end else begin
      if (wr_ctrl_b0) disp_on  <= WDATA[0];
      if (wr_int_b0)  int_enbl <= WDATA[0];

      vblank_flag <= VBLANK_PLS     | (vblank_flag & ~clr_vblank);
      int_flag    <= VBLANK_PLS     | (int_flag    & ~clr_int);
      fifo_under  <= FIFO_UNDER_PLS | (fifo_under  & ~clr_under);
      fifo_over   <= FIFO_OVER_PLS  | (fifo_over   & ~clr_over);
    end
  end

  // ---------------------------------------------------------------------------
  // Active display address and interrupt output.
  // disp_addr samples the shadow before any same-edge DISPADDR write lands, so
  // a write coincident with VBLANK_PLS is deferred to the next load point.
  // While the display is off the shadow is copied every cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      disp_addr <= '0;
      dsp_irq   <= 1'b0;
    end else begin
      if (VBLANK_PLS || !disp_on) disp_addr <= shadow_full;
      // Registered from the flag, so irq trails the flag by one cycle.
      dsp_irq <= int_flag & int_enbl;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: mux of current register values, registered on RDEN. A read
  // sampled on the same edge as a write therefore returns the pre-write value.
  // ---------------------------------------------------------------------------
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (RDADDR)
      ADDR_DISPADDR: rd_mux = shadow_full;
      ADDR_DISPCTRL: rd_mux = {30'd0, vblank_flag, disp_on};
      ADDR_DISPINT:  rd_mux = {29'd0, int_flag, 1'b0, int_enbl};
      ADDR_DISPFIFO: rd_mux = {30'd0, fifo_over, fifo_under};
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rdata <= '0;
    end else if (RDEN) begin
      rdata <= rd_mux;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign RDATA     = rdata;
  assign DISP_ADDR = disp_addr;
  assign DISP_ON   = disp_on;
  assign DSP_IRQ   = dsp_irq;

endmodule

// File: tb/tb_disp_regctrl.sv
module tb_disp_regctrl;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic [15:0] WRADDR = '0;
  logic [3:0]  BYTEEN = '0;
  logic        WREN = 1'b0;
  logic [31:0] WDATA = '0;
  logic [15:0] RDADDR = '0;
  logic        RDEN = 1'b0;
  logic [31:0] RDATA;
  logic        VBLANK_PLS = 1'b0;
  logic        FIFO_OVER_PLS = 1'b0;
  logic        FIFO_UNDER_PLS = 1'b0;
  logic [31:0] DISP_ADDR;
  logic        DISP_ON;
  logic        DSP_IRQ;

  disp_regctrl #(.C_ADDR_WIDTH(16), .C_DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN), .WDATA(WDATA),
    .RDADDR(RDADDR), .RDEN(RDEN), .RDATA(RDATA),
    .VBLANK_PLS(VBLANK_PLS), .FIFO_OVER_PLS(FIFO_OVER_PLS),
    .FIFO_UNDER_PLS(FIFO_UNDER_PLS),
    .DISP_ADDR(DISP_ADDR), .DISP_ON(DISP_ON), .DSP_IRQ(DSP_IRQ)
  );

  initial forever #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard queues: expected RDATA per sampled RDEN cycle, and expected
  // {DISP_ADDR, DISP_ON, DSP_IRQ} after each driven cycle.
  logic [31:0] rd_q[$];
  logic [33:0] out_q[$];

  // Reference model: architectural register contents as the host sees them.
  logic [31:0] m_shadow;
  logic        m_on, m_vb, m_ien, m_iflag, m_under, m_over;
  logic [31:0] m_da;
  logic        m_irq;
  logic        drv_prev_rden = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_shadow = '0; m_on = 0; m_vb = 0; m_ien = 0; m_iflag = 0;
    m_under = 0; m_over = 0; m_da = '0; m_irq = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [15:0] a);
    case (a)
      16'h0000: return m_shadow;
      16'h0004: return {30'd0, m_vb, m_on};
      16'h0008: return {29'd0, m_iflag, 1'b0, m_ien};
      16'h000C: return {30'd0, m_over, m_under};
      default:  return 32'd0;
    endcase
  endfunction

  // Advance the model across one clock edge with the given inputs.
  task automatic model_step(input logic wren, input logic [15:0] wa, input logic [3:0] be,
                            input logic [31:0] wd, input logic vbl, input logic ov,
                            input logic un, input logic rden, input logic [15:0] ra,
                            input bit use_c, input logic [31:0] c_exp);
    logic [31:0] nxt_da;
    logic        nxt_irq;
    logic        b0;
    if (rden) rd_q.push_back((use_c && !drv_prev_rden) ? c_exp : model_read(ra));
    drv_prev_rden = rden;
    // Display side is computed from the state before this edge's write.
    nxt_da  = (vbl || !m_on) ? m_shadow : m_da;
    nxt_irq = m_iflag & m_ien;
    b0 = wren && be[0];
    if (wren && wa == 16'h0000) begin
      for (int n = 0; n < 4; n++) if (be[n]) m_shadow[8*n +: 8] = wd[8*n +: 8];
      m_shadow[2:0] = 3'b000;
    end
    if (b0 && wa == 16'h0004) begin
      m_on = wd[0];
      if (wd[1]) m_vb = 0;
    end
    if (b0 && wa == 16'h0008) begin
      m_ien = wd[0];
      if (wd[1]) m_iflag = 0;
    end
    if (b0 && wa == 16'h000C) begin
      if (wd[0]) m_under = 0;
      if (wd[1]) m_over = 0;
    end
    // Hardware sets take priority over same-cycle clears.
    if (vbl) begin m_vb = 1; m_iflag = 1; end
    if (ov) m_over = 1;
    if (un) m_under = 1;
    m_da  = nxt_da;
    m_irq = nxt_irq;
    out_q.push_back({m_da, m_on, m_irq});
  endtask

  task automatic drive(input logic wren, input logic [15:0] wa, input logic [3:0] be,
                       input logic [31:0] wd, input logic rden, input logic [15:0] ra,
                       input logic vbl, input logic ov, input logic un,
                       input bit use_c, input logic [31:0] c_exp);
    @(negedge ACLK);
    WREN = wren; WRADDR = wa; BYTEEN = be; WDATA = wd;
    RDEN = rden; RDADDR = ra;
    VBLANK_PLS = vbl; FIFO_OVER_PLS = ov; FIFO_UNDER_PLS = un;
    model_step(wren, wa, be, wd, vbl, ov, un, rden, ra, use_c, c_exp);
  endtask

  task automatic idle();
    drive(0, 16'h0, 4'h0, 32'h0, 0, 16'h0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
    drive(1, a, be, d, 0, 16'h0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic pulse(input logic v, input logic o, input logic u);
    drive(0, 16'h0, 4'h0, 32'h0, 0, 16'h0, v, o, u, 0, 32'h0);
  endtask

  // Read whose first sampled value is pinned to a constant expectation.
  task automatic rd(input logic [15:0] a, input logic [31:0] exp);
    drive(0, 16'h0, 4'h0, 32'h0, 1, a, 0, 0, 0, 1, exp);
    drive(0, 16'h0, 4'h0, 32'h0, 1, a, 0, 0, 0, 0, 32'h0);
    idle();
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1:    return 16'h0000;
      2, 3:    return 16'h0004;
      4, 5:    return 16'h0008;
      6, 7:    return 16'h000C;
      8:       return 16'h8004;
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitor: compares outputs after every edge outside reset.
  logic [31:0] hold_exp = '0;
  logic        mon_rden;
  logic [33:0] mon_e;
  initial forever begin
    @(posedge ACLK);
    if (ARESET) begin
      hold_exp = '0;
    end else begin
      mon_rden = RDEN;
      #1;
      if (out_q.size() != 0) begin
        mon_e = out_q.pop_front();
        check("disp_addr", DISP_ADDR, mon_e[33:2]);
        check("disp_on", {31'd0, DISP_ON}, {31'd0, mon_e[1]});
        check("dsp_irq", {31'd0, DSP_IRQ}, {31'd0, mon_e[0]});
      end
      if (mon_rden) begin
        if (rd_q.size() == 0) begin
          n_checks++;
          $display("FAIL rd_queue: read with no expectation, got 0x%08h", RDATA);
        end else begin
          hold_exp = rd_q.pop_front();
          check("rdata", RDATA, hold_exp);
        end
      end else begin
        check("rdata_hold", RDATA, hold_exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks done", n_checks);
    $fatal(1);
  end

  initial begin
    model_reset();
    // Asynchronous reset: outputs clear with no clock edge in between.
    #3 ARESET = 1'b1;
    #1;
    check("rst_rdata", RDATA, 32'h0);
    check("rst_disp_addr", DISP_ADDR, 32'h0);
    check("rst_disp_on", {31'd0, DISP_ON}, 32'h0);
    check("rst_dsp_irq", {31'd0, DSP_IRQ}, 32'h0);
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;

    rd(16'h0000, 32'h0); rd(16'h0004, 32'h0);
    rd(16'h0008, 32'h0); rd(16'h000C, 32'h0);

    // Bytewise DISPADDR writes, display off so DISP_ADDR follows.
    wr(16'h0000, 4'b0001, 32'h12345678); rd(16'h0000, 32'h00000078);
    check("track_b0", DISP_ADDR, 32'h00000078);
    wr(16'h0000, 4'b0010, 32'h00005600); rd(16'h0000, 32'h00005678);
    wr(16'h0000, 4'b0100, 32'h00340000); rd(16'h0000, 32'h00345678);
    wr(16'h0000, 4'b1000, 32'h12000000); rd(16'h0000, 32'h12345678);
    check("track_b3", DISP_ADDR, 32'h12345678);

    // Shadowing with the display on.
    wr(16'h0004, 4'b0001, 32'h1);
    wr(16'h0000, 4'b1111, 32'h2004B000);
    idle();
    check("shadow_hold", DISP_ADDR, 32'h12345678);
    check("disp_on_set", {31'd0, DISP_ON}, 32'h1);
    pulse(1, 0, 0);
    check("shadow_pre_vbl", DISP_ADDR, 32'h12345678);
    idle();
    check("shadow_load", DISP_ADDR, 32'h2004B000);

    // VBLANK sticky flag.
    rd(16'h0004, 32'h3);
    wr(16'h0004, 4'b0001, 32'h3); rd(16'h0004, 32'h1);
    drive(1, 16'h0004, 4'b0001, 32'h3, 0, 16'h0, 1, 0, 0, 0, 32'h0);
    rd(16'h0004, 32'h3);

    // Interrupt timing.
    wr(16'h0008, 4'b0001, 32'h3);
    pulse(1, 0, 0);
    check("irq_c0", {31'd0, DSP_IRQ}, 32'h0);
    idle(); check("irq_c1", {31'd0, DSP_IRQ}, 32'h0);
    idle(); check("irq_c2", {31'd0, DSP_IRQ}, 32'h1);
    rd(16'h0008, 32'h5);
    wr(16'h0008, 4'b0001, 32'h3);
    check("irqclr_c0", {31'd0, DSP_IRQ}, 32'h1);
    idle(); check("irqclr_c1", {31'd0, DSP_IRQ}, 32'h1);
    idle(); check("irqclr_c2", {31'd0, DSP_IRQ}, 32'h0);
    rd(16'h0008, 32'h1);

    // FIFO flags.
    pulse(0, 1, 1); rd(16'h000C, 32'h3);
    wr(16'h000C, 4'b0001, 32'h1); rd(16'h000C, 32'h2);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int kind;
      logic [15:0] ra;
      kind = $urandom_range(0, 9);
      if (kind < 5) begin
        drive(1, rand_addr(), 4'($urandom_range(0, 15)), $urandom, 0, 16'h0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 9) == 0, 0, 32'h0);
      end else if (kind < 8) begin
        ra = rand_addr();
        drive($urandom_range(0, 1) == 1, rand_addr(), 4'($urandom_range(0, 15)), $urandom,
              1, ra, $urandom_range(0, 7) == 0, 0, 0, 0, 32'h0);
        drive($urandom_range(0, 1) == 1, rand_addr(), 4'($urandom_range(0, 15)), $urandom,
              1, ra, 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 0, 32'h0);
        pulse($urandom_range(0, 7) == 0, 0, 0);
      end else begin
        pulse($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      end
    end
    idle();

    // Build non-zero state, then reset in the middle of a read.
    wr(16'h0004, 4'b0001, 32'h1);
    wr(16'h0008, 4'b0001, 32'h1);
    pulse(1, 0, 0);
    idle(); idle();
    check("pre_rst_irq", {31'd0, DSP_IRQ}, 32'h1);
    pulse(0, 1, 1);
    drive(0, 16'h0, 4'h0, 32'h0, 1, 16'h000C, 0, 0, 0, 1, 32'h3);
    @(negedge ACLK);
    ARESET = 1'b1;
    WREN = 0; VBLANK_PLS = 0; FIFO_OVER_PLS = 0; FIFO_UNDER_PLS = 0;
    #1;
    check("midrd_rdata", RDATA, 32'h0);
    check("midrd_disp_addr", DISP_ADDR, 32'h0);
    check("midrd_disp_on", {31'd0, DISP_ON}, 32'h0);
    check("midrd_dsp_irq", {31'd0, DSP_IRQ}, 32'h0);
    model_reset();
    drv_prev_rden = 1'b0;
    repeat (2) @(negedge ACLK);
    RDEN = 1'b0;
    ARESET = 1'b0;
    rd(16'h0000, 32'h0); rd(16'h0004, 32'h0);
    rd(16'h0008, 32'h0); rd(16'h000C, 32'h0);
    idle(); idle();
    check("rd_q_drained", rd_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
